counter_bus_loader: RTL and testbench

- Peer controller on the far side of the shared 8-bit bidirectional uio bus of the free-running counter tile.
- Normally listens while the counter drives the bus and checks that successive values increment by one.
- On request, generates the counter's load control (the level the counter edge-detects after its one-flop synchroniser), drives a preload value during the counter's RELEASE/CAPTURE window, then verifies the counter adopted it.

---
 rtl/counter_bus_loader.sv | 147 ++++++++++++++
 tb/tb_counter_bus_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/counter_bus_loader.sv
// rtl/counter_bus_loader.sv - peer controller on the counter tile's shared uio bus
// Listens for +1 sequences while idle; on request, pulses load, drives a preload value, verifies adoption.
module counter_bus_loader #(
  parameter int WIDTH       = 8,
  parameter int REQ_CYCLES  = 2,
  parameter int DRIVE_START = 2,
  parameter int DRIVE_LEN   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             load_req,
  output logic             busy,
  output logic             done,
  output logic             load_ok,
  output logic [WIDTH-1:0] last_value,
  output logic             seq_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_DRIVE  = 3'd2;
  localparam logic [2:0] S_TURN   = 3'd3;
  localparam logic [2:0] S_VERIFY = 3'd4;

  localparam int K_W = $clog2(DRIVE_START + DRIVE_LEN + 2) + 1;
  // k holds n+1 after edge E+n, so the windows below are offset by one from edge numbers
  localparam logic [K_W-1:0] REQ_K  = K_W'(REQ_CYCLES);
  localparam logic [K_W-1:0] OE_LO  = K_W'(DRIVE_START);
  localparam logic [K_W-1:0] OE_HI  = K_W'(DRIVE_START + DRIVE_LEN);

  logic [2:0]       state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             load_req_q, load_req_d;
  logic             bus_oe_q, bus_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ok_q, load_ok_d;
  logic             hist_q, hist_d;
  logic             err_q, err_d;
  logic             new_err;
  logic [WIDTH-1:0] last_inc;

  assign last_inc = last_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    val_d      = val_q;
    last_d     = last_q;
    load_req_d = load_req_q;
    bus_oe_d   = bus_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_ok_d  = load_ok_q;
    hist_d     = hist_q;
    new_err    = 1'b0;

    // Monitor runs whenever not busy, which includes the done (VERIFY) cycle
    if (!busy_q) begin
      new_err = hist_q && (bus_in != last_inc);
      last_d  = bus_in;
      hist_d  = 1'b1;
    end

    case (state_q)
      S_IDLE, S_VERIFY: begin
        state_d = S_IDLE;
        if (start) begin
          val_d      = load_value;
          load_req_d = 1'b1;
          busy_d     = 1'b1;
          k_d        = K_W'(1);
          state_d    = S_REQ;
        end
      end
      S_REQ, S_DRIVE: begin
        k_d        = k_q + 1'b1;
        load_req_d = (k_d <= REQ_K);
        bus_oe_d   = (k_d > OE_LO) && (k_d <= OE_HI);
        if (bus_oe_d)
          state_d = S_DRIVE;
        else if (k_d > OE_HI)
          state_d = S_TURN;
        else
          state_d = S_REQ;
      end
      S_TURN: begin
        load_ok_d = (bus_in == val_q);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        last_d    = bus_in;
        hist_d    = 1'b1;
        k_d       = '0;
        state_d   = S_VERIFY;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = (err_q && !clr_err) || new_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      val_q      <= '0;
      last_q     <= '0;
      load_req_q <= 1'b0;
      bus_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_ok_q  <= 1'b0;
      hist_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      val_q      <= val_d;
      last_q     <= last_d;
      load_req_q <= load_req_d;
      bus_oe_q   <= bus_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_ok_q  <= load_ok_d;
      hist_q     <= hist_d;
      err_q      <= err_d;
    end
  end

  assign bus_out    = bus_oe_q ? val_q : '0;
  assign bus_oe     = bus_oe_q;
  assign load_req   = load_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ok    = load_ok_q;
  assign last_value = last_q;
  assign seq_err    = err_q;

endmodule

// File: tb/tb_counter_bus_loader.sv
// tb/tb_counter_bus_loader.sv - scoreboard bench for counter_bus_loader with a simple counter model
module tb_counter_bus_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] load_value;
  logic       clr_err;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       load_req;
  logic       busy;
  logic       done;
  logic       load_ok;
  logic [7:0] last_value;
  logic       seq_err;

  logic [7:0] man_val;
  logic       model_en;
  logic       ignore_load;
  logic [7:0] cnt;

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  counter_bus_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_value (load_value),
    .clr_err    (clr_err),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .load_req   (load_req),
    .busy       (busy),
    .done       (done),
    .load_ok    (load_ok),
    .last_value (last_value),
    .seq_err    (seq_err)
  );

  // Counter model: free-runs, adopts the driven value while bus_oe is high (or 0x33 when told to ignore)
  always @(posedge clk) begin
    if (!model_en)
      cnt <= man_val + 8'h01;
    else if (bus_oe)
      cnt <= ignore_load ? 8'h33 : bus_out;
    else
      cnt <= cnt + 8'h01;
  end

  assign bus_in = model_en ? cnt : man_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending transaction");
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("done_load_ok", load_ok, e[8]);
        chk("done_last_value", last_value, e[7:0]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_txn(input logic [7:0] v, input logic ign, input logic exp_ok, input logic [7:0] exp_last);
    ignore_load = ign;
    start       = 1'b1;
    load_value  = v;
    sb_q.push_back({exp_ok, exp_last});
    tick();
    start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      chk("txn_load_req", load_req, n < 2);
      chk("txn_bus_oe", bus_oe, (n == 2 || n == 3));
      chk("txn_bus_out", bus_out, (n == 2 || n == 3) ? v : 8'h00);
      chk("txn_busy", busy, n < 5);
      tick();
    end
    ignore_load = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b1;
    load_value  = 8'h00;
    clr_err     = 1'b0;
    man_val     = 8'h55;
    model_en    = 1'b0;
    ignore_load = 1'b0;
    tick();
    tick();
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_load_req", load_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_last_value", last_value, 0);

    start = 1'b0;
    rst_n = 1'b1;
    man_val = 8'h10; tick();
    man_val = 8'h11; tick();
    man_val = 8'h12; tick();
    chk("mon_last_value", last_value, 8'h12);
    chk("mon_no_err", seq_err, 0);
    man_val = 8'h14; tick();
    chk("mon_jump_err", seq_err, 1);
    man_val = 8'h15; tick();
    chk("mon_sticky", seq_err, 1);
    clr_err = 1'b1; man_val = 8'h16; tick();
    chk("mon_clr", seq_err, 0);
    man_val = 8'h20; tick();
    chk("mon_err_beats_clr", seq_err, 1);
    clr_err = 1'b0; man_val = 8'hFF; tick();
    clr_err = 1'b1; man_val = 8'h00; tick();
    chk("mon_wrap_legal", seq_err, 0);
    chk("mon_wrap_last", last_value, 8'h00);
    clr_err = 1'b0; man_val = 8'h01; tick();
    chk("mon_after_wrap", seq_err, 0);

    model_en = 1'b1;
    tick();
    tick();
    chk("model_handover", seq_err, 0);

    load_txn(8'hA5, 1'b0, 1'b1, 8'hA5);
    tick();
    chk("post_load_seq", seq_err, 0);

    load_txn(8'hC3, 1'b1, 1'b0, 8'h33);
    tick();
    chk("post_fail_seq", seq_err, 0);

    start      = 1'b1;
    load_value = 8'h3C;
    repeat (3) sb_q.push_back({1'b1, 8'h3C});
    tick();
    for (int n = 0; n < 18; n++) begin
      chk("cont_load_req", load_req, (n % 6) < 2);
      chk("cont_bus_oe", bus_oe, ((n % 6) == 2 || (n % 6) == 3));
      chk("cont_busy", busy, (n % 6) < 5);
      if (n == 12) start = 1'b0;
      tick();
    end
    chk("cont_seq", seq_err, 0);

    start      = 1'b1;
    load_value = 8'h5A;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_drive_oe", bus_oe, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_bus_oe", bus_oe, 0);
    chk("mid_rst_load_req", load_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_last", last_value, 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    load_txn(8'hA5, 1'b0, 1'b1, 8'hA5);
    tick();
    chk("final_seq", seq_err, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
